// File: rtl/ila_capture_ctrl_pkg.sv
// Shared constants for the ILA capture controller: trigger reduction selectors and FSM states.
package ila_capture_ctrl_pkg;

  localparam logic IOB_ILA_REDUCE_AND = 1'b0;
  localparam logic IOB_ILA_REDUCE_OR  = 1'b1;

  typedef enum logic [1:0] {
    IOB_ILA_ST_IDLE  = 2'd0,
    IOB_ILA_ST_ARMED = 2'd1,
    IOB_ILA_ST_POST  = 2'd2,
    IOB_ILA_ST_DONE  = 2'd3
  } ila_state_t;

endpackage

// File: rtl/ila_capture_ctrl_if.sv
// Write port of the ILA sample buffer; the capture controller drives it as master.
interface ila_capture_ctrl_if #(
  parameter int BUFFER_W   = 10,
  parameter int BUF_DATA_W = 32
);
  logic                  buf_wr_en;
  logic [BUFFER_W-1:0]   buf_wr_addr;
  logic [BUF_DATA_W-1:0] buf_wr_data;

  modport master (output buf_wr_en, output buf_wr_addr, output buf_wr_data);
  modport slave  (input  buf_wr_en, input  buf_wr_addr, input  buf_wr_data);
endinterface

// File: rtl/ila_trigger_reduce.sv
// Collapses the per-stage trigger bits into a single event, AND or OR selected at run time.
module ila_trigger_reduce
  import ila_capture_ctrl_pkg::*;
#(
  parameter int N_TRIG = 4
) (
  input  logic              reduce_type,
  input  logic [N_TRIG-1:0] trigger_in,
  output logic              trig
);

  assign trig = (reduce_type == IOB_ILA_REDUCE_AND) ? (&trigger_in) : (|trigger_in);

endmodule

// File: rtl/ila_capture_ctrl.sv
// ILA capture controller: arm/pre/post-trigger FSM driving a circular sample buffer.
// Optional IOB_ILA_TIMESTAMP_EN prepends a cycles-since-arm timestamp to each stored sample.
module ila_capture_ctrl
  import ila_capture_ctrl_pkg::*;
#(
  parameter int N_TRIG   = 4,
  parameter int DATA_W   = 32,
  parameter int BUFFER_W = 10,
  parameter int TS_W     = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                arm,
  input  logic                clear,
  input  logic                reduce_type,
  input  logic [N_TRIG-1:0]   trigger_in,
  input  logic                sample_en,
  input  logic [DATA_W-1:0]   sample_in,
  input  logic [BUFFER_W-1:0] post_trig,
  ila_capture_ctrl_if.master  wr_port,
  output logic [BUFFER_W-1:0] trig_addr,
  output logic [BUFFER_W:0]   n_samples,
  output logic                armed,
  output logic                triggered,
  output logic                done
);

`ifdef IOB_ILA_TIMESTAMP_EN
  localparam bit TS_EN = 1'b1;
`else
  localparam bit TS_EN = 1'b0;
`endif
  localparam int BUF_DATA_W = DATA_W + (TS_EN ? TS_W : 0);
  localparam logic [BUFFER_W-1:0] PTR_ONE = BUFFER_W'(1);

  // The top bit of the count is only ever set at exactly 2**BUFFER_W, so it doubles as the saturation flag.
  function automatic logic [BUFFER_W:0] sat_inc(input logic [BUFFER_W:0] v);
    return v[BUFFER_W] ? v : v + (BUFFER_W+1)'(1);
  endfunction

  logic                  trig;
  logic                  do_write;
  logic [BUFFER_W-1:0]   wr_ptr;
  logic [BUFFER_W-1:0]   remaining;
  logic [BUF_DATA_W-1:0] wr_word;
  ila_state_t            state;

  ila_trigger_reduce #(.N_TRIG(N_TRIG)) u_reduce (
    .reduce_type (reduce_type),
    .trigger_in  (trigger_in),
    .trig        (trig)
  );

`ifdef IOB_ILA_TIMESTAMP_EN
  logic [TS_W-1:0] ts;

  // Stored stamp is the cycle count since the arm edge, so a sample k edges after arm reads k.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       ts <= '0;
    else if (arm)  ts <= '0;
    else           ts <= ts + TS_W'(1);
  end

  assign wr_word = {ts + TS_W'(1), sample_in};
`else
  assign wr_word = sample_in;
`endif

  assign do_write = sample_en && (state == IOB_ILA_ST_ARMED || state == IOB_ILA_ST_POST);
  assign armed    = (state == IOB_ILA_ST_ARMED) || (state == IOB_ILA_ST_POST);
  assign done     = (state == IOB_ILA_ST_DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IOB_ILA_ST_IDLE;
      wr_ptr              <= '0;
      remaining           <= '0;
      trig_addr           <= '0;
      n_samples           <= '0;
      triggered           <= 1'b0;
      wr_port.buf_wr_en   <= 1'b0;
      wr_port.buf_wr_addr <= '0;
      wr_port.buf_wr_data <= '0;
    end else begin
      wr_port.buf_wr_en <= 1'b0;
      if (clear) begin
        state <= IOB_ILA_ST_IDLE;
      end else if (arm) begin
        state     <= IOB_ILA_ST_ARMED;
        wr_ptr    <= '0;
        remaining <= '0;
        trig_addr <= '0;
        n_samples <= '0;
        triggered <= 1'b0;
      end else if (do_write) begin
        wr_port.buf_wr_en   <= 1'b1;
        wr_port.buf_wr_addr <= wr_ptr;
        wr_port.buf_wr_data <= wr_word;
        wr_ptr              <= wr_ptr + PTR_ONE;
        n_samples           <= sat_inc(n_samples);
        if (state == IOB_ILA_ST_ARMED) begin
          if (trig) begin
            triggered <= 1'b1;
            trig_addr <= wr_ptr;
            remaining <= post_trig;
            state     <= (post_trig == '0) ? IOB_ILA_ST_DONE : IOB_ILA_ST_POST;
          end
        end else begin
          remaining <= remaining - PTR_ONE;
          if (remaining == PTR_ONE) state <= IOB_ILA_ST_DONE;
        end
      end
    end
  end

endmodule

// File: tb/tb_ila_capture_ctrl.sv
// Directed bench for ila_capture_ctrl (BUFFER_W=4): vector table plus hand-written capture sequences.
module tb_ila_capture_ctrl;

  localparam int N_TRIG   = 4;
  localparam int DATA_W   = 32;
  localparam int BUFFER_W = 4;
  localparam int TS_W     = 16;
`ifdef IOB_ILA_TIMESTAMP_EN
  localparam int BUF_DATA_W = DATA_W + TS_W;
`else
  localparam int BUF_DATA_W = DATA_W;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                arm, clear, reduce_type, sample_en;
  logic [N_TRIG-1:0]   trigger_in;
  logic [DATA_W-1:0]   sample_in;
  logic [BUFFER_W-1:0] post_trig;
  logic [BUFFER_W-1:0] trig_addr;
  logic [BUFFER_W:0]   n_samples;
  logic                armed, triggered, done;

  int n_vec  = 0;
  int n_fail = 0;

  ila_capture_ctrl_if #(.BUFFER_W(BUFFER_W), .BUF_DATA_W(BUF_DATA_W)) wr_port ();

  ila_capture_ctrl #(
    .N_TRIG(N_TRIG), .DATA_W(DATA_W), .BUFFER_W(BUFFER_W), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst(rst), .arm(arm), .clear(clear), .reduce_type(reduce_type),
    .trigger_in(trigger_in), .sample_en(sample_en), .sample_in(sample_in),
    .post_trig(post_trig), .wr_port(wr_port), .trig_addr(trig_addr),
    .n_samples(n_samples), .armed(armed), .triggered(triggered), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        a, c, r;
    logic [3:0]  t;
    logic        s;
    logic [31:0] d;
    logic [3:0]  p;
    logic        e_wr;
    logic [3:0]  e_addr;
    logic [3:0]  e_taddr;
    logic [4:0]  e_n;
    logic        e_armed, e_trg, e_done;
  } vec_t;

  vec_t vt[13];

  function automatic vec_t mk(input logic a, c, r, input logic [3:0] t, input logic s,
                              input logic [31:0] d, input logic [3:0] p, input logic ew,
                              input logic [3:0] ea, input logic [3:0] eta, input logic [4:0] en,
                              input logic eam, etg, edn);
    vec_t v;
    v.a = a; v.c = c; v.r = r; v.t = t; v.s = s; v.d = d; v.p = p;
    v.e_wr = ew; v.e_addr = ea; v.e_taddr = eta; v.e_n = en;
    v.e_armed = eam; v.e_trg = etg; v.e_done = edn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic a, c, r, input logic [3:0] t, input logic s,
                       input logic [31:0] d, input logic [3:0] p);
    arm = a; clear = c; reduce_type = r; trigger_in = t; sample_en = s;
    sample_in = d; post_trig = p;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag, input logic ew, input logic [3:0] ea,
                         input logic [3:0] eta, input logic [4:0] en,
                         input logic eam, etg, edn);
    chk({tag, ".wr_en"}, 64'(wr_port.buf_wr_en), 64'(ew));
    if (ew) chk({tag, ".wr_addr"}, 64'(wr_port.buf_wr_addr), 64'(ea));
    chk({tag, ".trig_addr"}, 64'(trig_addr), 64'(eta));
    chk({tag, ".n_samples"}, 64'(n_samples), 64'(en));
    chk({tag, ".armed"}, 64'(armed), 64'(eam));
    chk({tag, ".triggered"}, 64'(triggered), 64'(etg));
    chk({tag, ".done"}, 64'(done), 64'(edn));
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".wr_en"}, 64'(wr_port.buf_wr_en), 64'd0);
    chk({tag, ".wr_addr"}, 64'(wr_port.buf_wr_addr), 64'd0);
    chk({tag, ".wr_data"}, 64'(wr_port.buf_wr_data), 64'd0);
    chk({tag, ".trig_addr"}, 64'(trig_addr), 64'd0);
    chk({tag, ".n_samples"}, 64'(n_samples), 64'd0);
    chk({tag, ".armed"}, 64'(armed), 64'd0);
    chk({tag, ".triggered"}, 64'(triggered), 64'd0);
    chk({tag, ".done"}, 64'(done), 64'd0);
  endtask

  initial begin
    logic [BUF_DATA_W-1:0] exp_word;

    //            a  c  r  trig     se data          pt   wr addr taddr n   arm trg done
    vt[0]  = mk(1, 0, 0, 4'b0000, 0, 32'h0,        4'd0, 0, 4'd0, 4'd0, 5'd0, 1, 0, 0);
    vt[1]  = mk(0, 0, 0, 4'b1110, 1, 32'hA1,       4'd0, 1, 4'd0, 4'd0, 5'd1, 1, 0, 0);
    vt[2]  = mk(0, 0, 0, 4'b1111, 0, 32'hA2,       4'd0, 0, 4'd0, 4'd0, 5'd1, 1, 0, 0);
    vt[3]  = mk(0, 0, 0, 4'b1111, 1, 32'hA3,       4'd0, 1, 4'd1, 4'd1, 5'd2, 0, 1, 1);
    vt[4]  = mk(0, 0, 0, 4'b1111, 1, 32'hA4,       4'd0, 0, 4'd0, 4'd1, 5'd2, 0, 1, 1);
    vt[5]  = mk(0, 0, 0, 4'b0000, 1, 32'hA5,       4'd0, 0, 4'd0, 4'd1, 5'd2, 0, 1, 1);
    vt[6]  = mk(1, 0, 0, 4'b0000, 0, 32'hA6,       4'd0, 0, 4'd0, 4'd0, 5'd0, 1, 0, 0);
    vt[7]  = mk(0, 0, 0, 4'b1111, 1, 32'hA7,       4'd3, 1, 4'd0, 4'd0, 5'd1, 1, 1, 0);
    vt[8]  = mk(1, 1, 0, 4'b1111, 1, 32'hA8,       4'd3, 0, 4'd0, 4'd0, 5'd1, 0, 1, 0);
    vt[9]  = mk(0, 0, 0, 4'b1111, 1, 32'hA9,       4'd3, 0, 4'd0, 4'd0, 5'd1, 0, 1, 0);
    vt[10] = mk(1, 0, 0, 4'b1111, 1, 32'hAA,       4'd3, 0, 4'd0, 4'd0, 5'd0, 1, 0, 0);
    vt[11] = mk(0, 0, 1, 4'b0001, 1, 32'hAB,       4'd2, 1, 4'd0, 4'd0, 5'd1, 1, 1, 0);
    vt[12] = mk(0, 1, 1, 4'b0000, 1, 32'hAC,       4'd2, 0, 4'd0, 4'd0, 5'd1, 0, 1, 0);

    rst = 1'b1; arm = 0; clear = 0; reduce_type = 0; trigger_in = '0;
    sample_en = 0; sample_in = '0; post_trig = '0;
    #12;
    chk_all_zero("reset");
    rst = 1'b0;

    // AND/OR reduction, sample qualification, DONE hold, arm/clear priority
    for (int i = 0; i < 13; i++) begin
      drive(vt[i].a, vt[i].c, vt[i].r, vt[i].t, vt[i].s, vt[i].d, vt[i].p);
      chk_out($sformatf("vec%0d", i), vt[i].e_wr, vt[i].e_addr, vt[i].e_taddr,
              vt[i].e_n, vt[i].e_armed, vt[i].e_trg, vt[i].e_done);
      if (vt[i].e_wr)
        chk($sformatf("vec%0d.wr_data", i), 64'(wr_port.buf_wr_data[DATA_W-1:0]), 64'(vt[i].d));
    end

    // OR trigger on 6th sample, post_trig=3: nine writes at 0..8, none after
    drive(1, 0, 1, 4'b0000, 0, 32'h0, 4'd3);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 1, (i == 5) ? 4'b0010 : 4'b0000, 1, 32'h100 + i, 4'd3);
      if (i < 9) begin
        chk_out($sformatf("seq2.s%0d", i), 1'b1, 4'(i), (i >= 5) ? 4'd5 : 4'd0,
                5'(i + 1), (i < 8), (i >= 5), (i == 8));
        chk($sformatf("seq2.s%0d.wr_data", i), 64'(wr_port.buf_wr_data[DATA_W-1:0]),
            64'(32'h100 + i));
      end else begin
        chk_out("seq2.after", 1'b0, 4'd0, 4'd5, 5'd9, 1'b0, 1'b1, 1'b1);
      end
    end

    // 20 pre-trigger samples wrap the pointer, count saturates at 16
    drive(1, 0, 1, 4'b0000, 0, 32'h0, 4'd2);
    for (int i = 0; i < 23; i++) begin
      drive(0, 0, 1, (i == 20) ? 4'b0001 : 4'b0000, 1, 32'h200 + i, 4'd2);
      chk_out($sformatf("seq3.s%0d", i), 1'b1, 4'(i % 16), (i >= 20) ? 4'd4 : 4'd0,
              (i >= 15) ? 5'd16 : 5'(i + 1), (i < 22), (i >= 20), (i == 22));
    end
    drive(0, 0, 1, 4'b0001, 1, 32'h2FF, 4'd2);
    chk_out("seq3.after", 1'b0, 4'd0, 4'd4, 5'd16, 1'b0, 1'b1, 1'b1);

    // asynchronous reset while in POST
    drive(1, 0, 0, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 0, 4'b1111, 1, 32'h301, 4'd5);
    drive(0, 0, 0, 4'b0000, 1, 32'h302, 4'd5);
    chk_out("seq1.post", 1'b1, 4'd1, 4'd0, 5'd2, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    #2;
    chk_all_zero("seq1.rst");
    rst = 1'b0;
    drive(0, 0, 0, 4'b1111, 1, 32'h303, 4'd5);
    chk_out("seq1.idle0", 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 0, 4'b1111, 1, 32'h304, 4'd5);
    chk_out("seq1.idle1", 1'b0, 4'd0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0);
    drive(1, 0, 0, 4'b0000, 0, 32'h0, 4'd5);
    chk_out("seq1.rearm", 1'b0, 4'd0, 4'd0, 5'd0, 1'b1, 1'b0, 1'b0);

    // write data word: samples 3 and 7 edges after arm
    drive(1, 0, 1, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 1, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 1, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 1, 4'b0000, 1, 32'hDEAD0003, 4'd5);
`ifdef IOB_ILA_TIMESTAMP_EN
    exp_word = {16'd3, 32'hDEAD0003};
`else
    exp_word = 32'hDEAD0003;
`endif
    chk("seq6.t3.wr_data", 64'(wr_port.buf_wr_data), 64'(exp_word));
    drive(0, 0, 1, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 1, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 1, 4'b0000, 0, 32'h0, 4'd5);
    drive(0, 0, 1, 4'b0000, 1, 32'hBEEF0007, 4'd5);
`ifdef IOB_ILA_TIMESTAMP_EN
    exp_word = {16'd7, 32'hBEEF0007};
`else
    exp_word = 32'hBEEF0007;
`endif
    chk("seq6.t7.wr_data", 64'(wr_port.buf_wr_data), 64'(exp_word));
    chk("seq6.t7.wr_addr", 64'(wr_port.buf_wr_addr), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
